// File: rtl/rfid_frame_parser_pkg.sv
// Shared definitions for the RFID frame parser and its consumers.
//  - Frame delimiters and the "no tag" value carried on rfid_rxd.
//  - Parser FSM state encoding.
//  - Saturating 8-bit increment used for the error counter.
package rfid_frame_parser_pkg;

  localparam logic [7:0] RFID_SOF    = 8'h02;
  localparam logic [7:0] RFID_EOF    = 8'h03;
  localparam logic [7:0] RFID_NO_TAG = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_TAIL = 3'd4
  } rfid_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rfid_timeout_cnt.sv
// Down-counting timeout with terminal-count compare.
//  clr loads the counter; en lets it count down until it sits at zero.
//  expired is high during the LIMIT-th cycle after the clr strobe and stays
//  high until the next clr. Reset leaves the counter at zero (expired).
// Ports:
//  clk      in  system clock
//  rst      in  asynchronous reset, active-low
//  clr      in  restart the timeout
//  en       in  count enable
//  expired  out timeout reached
module rfid_timeout_cnt #(
  parameter int LIMIT = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  // Loading LIMIT-1 makes the zero compare land exactly LIMIT edges after clr,
  // so the consumer acts on the LIMIT-th edge rather than one later.
  localparam logic [W-1:0] RELOAD = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= RELOAD;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = (r_cnt == '0);

endmodule

// File: rtl/rfid_frame_parser.sv
// RFID reader frame parser.
//  Frame: 02 | LEN | PAYLOAD[0..LEN-1] | CSUM | 03, CSUM = LEN ^ PAYLOAD[*].
//  Good frames latch payload byte ID_IDX onto rfid_rxd, which is held for
//  HOLD_CYCLES after the last good frame and then returns to 0 (no tag).
// Ports:
//  clk        in   system clock
//  rst        in   asynchronous reset, active-low
//  rx_data    in   8  byte from the UART receiver
//  rx_valid   in   1  strobe, rx_data valid this cycle
//  rfid_rxd   out  8  latched tag ID, 0 = none
//  frame_ok   out  1  pulse, frame accepted
//  frame_err  out  1  pulse, frame aborted (length, checksum, trailer, timeout)
//  err_cnt    out  8  saturating count of frame_err pulses
//
// state   | meaning
// IDLE    | hunting for 02; other bytes are dropped silently
// LEN     | next byte is the payload length (1..MAX_LEN)
// DATA    | collecting payload, folding into checksum, capturing the ID byte
// CSUM    | next byte must equal the running checksum
// TAIL    | next byte must be 03
module rfid_frame_parser
  import rfid_frame_parser_pkg::*;
#(
  parameter int MAX_LEN      = 8,
  parameter int ID_IDX       = 0,
  parameter int BYTE_TIMEOUT = 50_000,
  parameter int HOLD_CYCLES  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] rfid_rxd,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [LW-1:0] ID_IDX_L  = LW'(ID_IDX);

  rfid_state_e r_state;
  rfid_state_e w_state_nxt;

  logic [LW-1:0] r_len;
  logic [LW-1:0] r_idx;
  logic [7:0]    r_csum;
  logic [7:0]    r_id_tmp;
  logic [7:0]    r_rfid_rxd;
  logic          r_frame_ok;
  logic          r_frame_err;
  logic [7:0]    r_err_cnt;

  logic w_accept;
  logic w_abort;
  logic w_gap_expired;
  logic w_hold_expired;

  rfid_timeout_cnt #(.LIMIT(BYTE_TIMEOUT)) u_gap_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (rx_valid),
    .en      (r_state != ST_IDLE),
    .expired (w_gap_expired)
  );

  rfid_timeout_cnt #(.LIMIT(HOLD_CYCLES)) u_hold_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_accept),
    .en      (1'b1),
    .expired (w_hold_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    if (rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == RFID_SOF) w_state_nxt = ST_LEN;
        end
        ST_LEN: begin
          if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
            w_abort     = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_idx == (r_len - 1'b1)) w_state_nxt = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_data != r_csum) begin
            w_abort     = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_TAIL;
          end
        end
        ST_TAIL: begin
          if (rx_data == RFID_EOF) w_accept = 1'b1;
          else                     w_abort  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if ((r_state != ST_IDLE) && w_gap_expired) begin
      // A byte landing on the expiry cycle takes the branch above instead.
      w_abort     = 1'b1;
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len       <= '0;
      r_idx       <= '0;
      r_csum      <= 8'h00;
      r_id_tmp    <= 8'h00;
      r_rfid_rxd  <= RFID_NO_TAG;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= 8'h00;
    end else begin
      r_frame_ok  <= w_accept;
      r_frame_err <= w_abort;
      if (w_abort) r_err_cnt <= sat_inc8(r_err_cnt);

      // Accept has priority over hold expiry so a fresh ID never blinks to 0.
      if (w_accept)            r_rfid_rxd <= r_id_tmp;
      else if (w_hold_expired) r_rfid_rxd <= RFID_NO_TAG;

      if (rx_valid) begin
        case (r_state)
          ST_LEN: begin
            r_len    <= rx_data[LW-1:0];
            r_csum   <= rx_data;
            r_idx    <= '0;
            // Cleared so a frame shorter than ID_IDX+1 reports no tag.
            r_id_tmp <= 8'h00;
          end
          ST_DATA: begin
            r_csum <= r_csum ^ rx_data;
            if (r_idx == ID_IDX_L) r_id_tmp <= rx_data;
            r_idx <= r_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rfid_rxd  = r_rfid_rxd;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_rfid_frame_parser.sv
// Directed bench for rfid_frame_parser with short timeouts.
module tb_rfid_frame_parser;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] rfid_rxd;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ok    = 0;
  int n_err   = 0;
  int n_both  = 0;
  int e0;
  int o0;

  always #5 clk = ~clk;

  rfid_frame_parser #(
    .MAX_LEN      (8),
    .ID_IDX       (0),
    .BYTE_TIMEOUT (20),
    .HOLD_CYCLES  (200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rfid_rxd  (rfid_rxd),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  always @(negedge clk) begin
    if (frame_ok)              n_ok++;
    if (frame_err)             n_err++;
    if (frame_ok && frame_err) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Bytes packed MSB-first: v = 64'h02_01_11_10_03, n = 5.
  task automatic send_bytes(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_byte(v[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_rxd", 32'(rfid_rxd), 0);
    chk("rst_ok", 32'(frame_ok), 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_errcnt", 32'(err_cnt), 0);

    // 1: basic good frame
    do_reset();
    o0 = n_ok;
    send_bytes(64'h02_01_11_10, 4);
    chk("t1_pre_rxd", 32'(rfid_rxd), 0);
    send_byte(8'h03);
    chk("t1_rxd", 32'(rfid_rxd), 32'h11);
    chk("t1_ok_pulse", 32'(frame_ok), 1);
    idle(3);
    chk("t1_ok_count", 32'(n_ok - o0), 1);
    chk("t1_errcnt", 32'(err_cnt), 0);

    // 2: hold expiry exactly 200 cycles after accept
    do_reset();
    send_bytes(64'h02_01_09_08_03, 5);
    chk("t2_rxd", 32'(rfid_rxd), 32'h09);
    idle(199);
    chk("t2_hold_199", 32'(rfid_rxd), 32'h09);
    idle(1);
    chk("t2_drop_200", 32'(rfid_rxd), 0);

    // 3: bad checksum after a good multi-byte frame
    do_reset();
    send_bytes(64'h02_02_11_22_31_03, 6);
    chk("t3_good_rxd", 32'(rfid_rxd), 32'h11);
    e0 = n_err;
    send_bytes(64'h02_02_11_22_00, 5);
    chk("t3_err_pulse", 32'(frame_err), 1);
    send_byte(8'h03);
    idle(2);
    chk("t3_err_count", 32'(n_err - e0), 1);
    chk("t3_errcnt", 32'(err_cnt), 1);
    chk("t3_rxd_kept", 32'(rfid_rxd), 32'h11);
    send_bytes(64'h02_01_09_08_03, 5);
    chk("t3_next_rxd", 32'(rfid_rxd), 32'h09);

    // 4: byte timeout, then just-in-time gap
    do_reset();
    e0 = n_err;
    o0 = n_ok;
    send_bytes(64'h02_01_11, 3);
    idle(25);
    send_bytes(64'h10_03, 2);
    idle(2);
    chk("t4_to_err", 32'(n_err - e0), 1);
    chk("t4_to_errcnt", 32'(err_cnt), 1);
    chk("t4_to_rxd", 32'(rfid_rxd), 0);
    chk("t4_to_no_ok", 32'(n_ok - o0), 0);
    send_bytes(64'h02_01_11, 3);
    idle(19);
    send_bytes(64'h10_03, 2);
    chk("t4_gap19_rxd", 32'(rfid_rxd), 32'h11);
    chk("t4_gap19_errcnt", 32'(err_cnt), 1);

    // 5: length errors, max length, saturation
    do_reset();
    send_bytes(64'h02_00, 2);
    chk("t5_len0_pulse", 32'(frame_err), 1);
    chk("t5_len0_errcnt", 32'(err_cnt), 1);
    send_bytes(64'h02_09, 2);
    chk("t5_len9_pulse", 32'(frame_err), 1);
    chk("t5_len9_errcnt", 32'(err_cnt), 2);
    send_bytes(64'h02_08, 2);
    send_bytes(64'h11_22_33_44_55_66_77_88, 8);
    send_bytes(64'h80_03, 2);
    chk("t5_len8_rxd", 32'(rfid_rxd), 32'h11);
    chk("t5_len8_errcnt", 32'(err_cnt), 2);
    for (int i = 0; i < 100; i++) send_bytes(64'h02_00, 2);
    idle(1);
    chk("t5_errcnt_102", 32'(err_cnt), 102);
    for (int i = 0; i < 200; i++) send_bytes(64'h02_00, 2);
    idle(1);
    chk("t5_errcnt_sat", 32'(err_cnt), 32'hFF);

    // 6: reset mid-payload
    do_reset();
    send_bytes(64'h02_01_11_10_03, 5);
    chk("t6_pre_rxd", 32'(rfid_rxd), 32'h11);
    send_bytes(64'h02_03_11, 3);
    e0 = n_err;
    rst = 1'b0;
    #2;
    chk("t6_rst_rxd", 32'(rfid_rxd), 0);
    chk("t6_rst_ok", 32'(frame_ok), 0);
    chk("t6_rst_err", 32'(frame_err), 0);
    chk("t6_rst_errcnt", 32'(err_cnt), 0);
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    idle(30);
    chk("t6_no_err", 32'(n_err - e0), 0);
    send_bytes(64'h02_01_11_10_03, 5);
    chk("t6_rxd", 32'(rfid_rxd), 32'h11);
    chk("t6_errcnt", 32'(err_cnt), 0);

    // 7: SOF value inside payload is data; same-ID frame reloads the hold
    do_reset();
    send_bytes(64'h02_01_02_03_03, 5);
    chk("t7_sof_data_rxd", 32'(rfid_rxd), 32'h02);
    send_bytes(64'h02_01_11_10_03, 5);
    idle(150);
    send_bytes(64'h02_01_11_10_03, 5);
    idle(150);
    chk("t7_reload_rxd", 32'(rfid_rxd), 32'h11);
    idle(50);
    chk("t7_reload_drop", 32'(rfid_rxd), 0);

    chk("ok_err_exclusive", 32'(n_both), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
